// File: rtl/streamer_pkg.sv
// Shared types and constants for the register-to-ASCII streamer.
// Holds the FSM state type, the ASCII digit codes and the number of bytes per value.
package streamer_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [7:0] ASCII_ONE       = 8'h31;
    localparam int         BYTES_PER_VALUE = 6;

endpackage

// File: rtl/bin_to_ascii_5.sv
// Converts a 5-bit value into five ASCII '0'/'1' characters.
// Value bit i lands in byte i, so bit 4 is the top byte of the 40-bit output.
module bin_to_ascii_5
    import streamer_pkg::*;
(
    input  logic [4:0]  value_i,
    output logic [39:0] ascii_o
);

    always_comb begin
        ascii_o = '0;
        for (int i = 0; i < 5; i++) begin
            ascii_o[i*8 +: 8] = value_i[i] ? ASCII_ONE : ASCII_ZERO;
        end
    end

endmodule

// File: rtl/reg_ascii_streamer.sv
// Round-robin collects 5-bit values from NUM_REQ requesters and streams each one
// as five ASCII binary digits (MSB first) followed by SEP_CHAR.
module reg_ascii_streamer
    import streamer_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*5-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int         IdxW     = $clog2(NUM_REQ);
    localparam logic [2:0] LastByte = 3'(BYTES_PER_VALUE - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [4:0]      value_q, value_d;
    logic [2:0]      cnt_q, cnt_d;

    logic [IdxW-1:0] grant_idx;
    logic            grant_any;
    logic [39:0]     ascii;

    bin_to_ascii_5 u_bin_to_ascii (
        .value_i (value_q),
        .ascii_o (ascii)
    );

    // Scan farthest-first so the nearest valid requester after last_grant overwrites.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
                grant_idx = IdxW'((int'(last_grant_q) + k) % NUM_REQ);
                grant_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        value_d      = value_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        busy         = 1'b0;
        unique case (state_q)
            StIdle: begin
                // rst_n gates the strobe so nothing is offered while reset is held.
                if (grant_any && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    value_d              = req_data[int'(grant_idx)*5 +: 5];
                    last_grant_d         = grant_idx;
                    cnt_d                = '0;
                    state_d              = StSend;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                case (cnt_q)
                    3'd0:    out_data = ascii[39:32];
                    3'd1:    out_data = ascii[31:24];
                    3'd2:    out_data = ascii[23:16];
                    3'd3:    out_data = ascii[15:8];
                    3'd4:    out_data = ascii[7:0];
                    default: out_data = SEP_CHAR;
                endcase
                if (out_ready) begin
                    if (cnt_q == LastByte) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            value_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            value_q      <= value_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_ascii_streamer.sv
// Self-checking bench: a byte-queue model of the streamer checked every cycle,
// plus literal byte/grant expectations for the directed scenarios.
module tb_reg_ascii_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        busy;

    logic [1:0]  req_valid2 = '0;
    logic [9:0]  req_data2 = '0;
    logic [1:0]  req_ready2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic        out_ready2 = 1'b0;
    logic        busy2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] mq[$];
    int         m_last = 3;

    logic [7:0] byte_log[$];
    int         grant_log[$];
    int         grant_cyc[$];
    logic [3:0] grant_raw[$];
    logic [7:0] byte_log2[$];
    logic [1:0] grant_raw2[$];

    reg_ascii_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    reg_ascii_streamer #(
        .NUM_REQ  (2),
        .SEP_CHAR (8'h0A)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid2),
        .req_data  (req_data2),
        .req_ready (req_ready2),
        .out_valid (out_valid2),
        .out_data  (out_data2),
        .out_ready (out_ready2),
        .busy      (busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // Model: the queue holds bytes still owed; empty queue means idle.
    always @(negedge clk) begin : model_cmp
        logic [3:0] e_ready;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] v;
        int         g;
        e_ready = '0;
        e_valid = 1'b0;
        e_data  = 8'h00;
        g       = -1;
        if (rst_n) begin
            if (mq.size() == 0) begin
                g = pick(req_valid, m_last);
                if (g >= 0) e_ready[g] = 1'b1;
            end else begin
                e_valid = 1'b1;
                e_data  = mq[0];
            end
        end
        check("cyc_req_ready", {60'd0, req_ready}, {60'd0, e_ready});
        check("cyc_out_valid", {63'd0, out_valid}, {63'd0, e_valid});
        check("cyc_out_data", {56'd0, out_data}, {56'd0, e_data});
        check("cyc_busy", {63'd0, busy}, {63'd0, e_valid});

        if (out_valid && out_ready) byte_log.push_back(out_data);
        if (req_ready != '0) begin
            grant_log.push_back(oh_idx(req_ready));
            grant_cyc.push_back(cyc);
            grant_raw.push_back(req_ready);
        end
        if (out_valid2 && out_ready2) byte_log2.push_back(out_data2);
        if (req_ready2 != '0) grant_raw2.push_back(req_ready2);

        if (!rst_n) begin
            mq.delete();
            m_last = 3;
        end else if (mq.size() == 0) begin
            if (g >= 0) begin
                v = req_data[g*5 +: 5];
                for (int b = 4; b >= 0; b--) mq.push_back(v[b] ? 8'h31 : 8'h30);
                mq.push_back(8'h20);
                m_last = g;
            end
        end else if (out_ready) begin
            void'(mq.pop_front());
        end
    end

    task automatic clear_logs();
        byte_log.delete();
        grant_log.delete();
        grant_cyc.delete();
        grant_raw.delete();
    endtask

    task automatic check_stream(input string nm, input logic [7:0] got[$],
                                input logic [7:0] e[6]);
        check({nm, "_len"}, 64'(got.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) check($sformatf("%s_b%0d", nm, i), {56'd0, got[i]}, {56'd0, e[i]});
        end
    endtask

    // One-shot request on an idle DUT: granted on the first edge, then withdrawn.
    task automatic send(input int idx, input logic [4:0] val);
        @(posedge clk); #1;
        req_data[idx*5 +: 5] = val;
        req_valid = 4'(1 << idx);
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] e[6];
        int found;

        // Reset holds outputs quiet even with requests pending.
        req_valid = 4'b1111;
        #12;
        check("rst_req_ready", {60'd0, req_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {56'd0, out_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single value from requester 0.
        clear_logs();
        out_ready = 1'b1;
        send(0, 5'b10110);
        repeat (8) @(posedge clk);
        #1;
        e = '{8'h31, 8'h30, 8'h31, 8'h31, 8'h30, 8'h20};
        check_stream("single", byte_log, e);
        check("single_grants", 64'(grant_raw.size()), 64'd1);
        if (grant_raw.size() > 0) check("single_ready", {60'd0, grant_raw[0]}, 64'h1);
        check("single_busy_after", {63'd0, busy}, 64'd0);

        // Fairness from a fresh reset.
        do_reset();
        clear_logs();
        req_data  = {5'b00011, 5'b00010, 5'b00001, 5'b00000};
        req_valid = 4'b1111;
        repeat (36) @(posedge clk);
        #1;
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        check("fair_count", {63'd0, grant_log.size() >= 5}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) begin
                check($sformatf("fair_order%0d", i), 64'(grant_log[i]), 64'(i % 4));
                if (i > 0) check($sformatf("fair_gap%0d", i),
                                 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd7);
            end
        end

        // Backpressure with out_ready pattern 1,0,0 repeating.
        clear_logs();
        send(2, 5'b00001);
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 3 == 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h20};
        check_stream("bp", byte_log, e);

        // Reset in the middle of a value.
        clear_logs();
        send(3, 5'b11111);
        for (int t = 0; t < 40 && byte_log.size() < 2; t++) @(posedge clk);
        check("mid_two_bytes", {63'd0, byte_log.size() >= 2}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        clear_logs();
        req_data  = {5'b11111, 5'b11111, 5'b11111, 5'b00000};
        req_valid = 4'b1001;
        @(posedge clk); #1;
        rst_n = 1'b1;
        found = 0;
        for (int t = 0; t < 20 && grant_log.size() == 0; t++) @(posedge clk);
        #1;
        req_valid = '0;
        check("mid_regrant_seen", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() > 0) check("mid_regrant_idx", 64'(grant_log[0]), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20};
        check_stream("mid_after", byte_log, e);

        // Input changes during a value do not disturb it.
        clear_logs();
        send(1, 5'b01010);
        req_data = 20'hFFFFF;
        repeat (8) @(posedge clk);
        #1;
        e = '{8'h30, 8'h31, 8'h30, 8'h31, 8'h30, 8'h20};
        check_stream("chg", byte_log, e);

        // Two-requester instance with a newline separator.
        @(posedge clk); #1;
        req_data2[9:5] = 5'b00000;
        req_valid2     = 2'b10;
        out_ready2     = 1'b1;
        @(posedge clk); #1;
        req_valid2 = '0;
        repeat (8) @(posedge clk);
        #1;
        e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
        check_stream("n2", byte_log2, e);
        check("n2_grants", 64'(grant_raw2.size()), 64'd1);
        if (grant_raw2.size() > 0) check("n2_ready", {62'd0, grant_raw2[0]}, 64'h2);
        check("n2_busy_after", {63'd0, busy2}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_ascii_streamer.md
REG_ASCII_STREAMER -- requirements
Module: reg_ascii_streamer

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter SEP_CHAR, default 8'h20, separator byte sent after each value.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester value available.
REQ-006 SHALL have port req_data  input  NUM_REQ*5  packed 5-bit values; requester i at [i*5 +: 5].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot grant/accept strobe.
REQ-008 SHALL have port out_valid  output  1  ASCII byte available.
REQ-009 SHALL have port out_data  output  8  ASCII byte.
REQ-010 SHALL have port out_ready  input  1  downstream sink accepts byte.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SEND; no other states.
REQ-013 In IDLE, SHALL select one requester with req_valid high by round-robin, starting search at (last_grant+1) mod NUM_REQ.
REQ-014 SHALL drive req_ready combinationally, one-hot, only in IDLE, only for the selected requester; all zeros otherwise.
REQ-015 Handshake req_valid[g] & req_ready[g] SHALL capture req_data[g] into a 5-bit value register, update last_grant to g, clear byte counter, and enter SEND next cycle.
REQ-016 In IDLE with no req_valid, SHALL remain IDLE, last_grant unchanged.
REQ-017 Requester deasserting req_valid before handshake SHALL be harmless; arbitration is re-evaluated every IDLE cycle.
REQ-018 In SEND, SHALL emit 6 bytes in order: ASCII of value bit 4, 3, 2, 1, 0 ('1'=8'h31, '0'=8'h30), then SEP_CHAR.
REQ-019 out_valid SHALL be high throughout SEND; out_data SHALL be stable while out_valid & !out_ready.
REQ-020 Byte counter (0..5) SHALL advance only on out_valid & out_ready.
REQ-021 Acceptance of byte 5 (SEP_CHAR) SHALL return FSM to IDLE next cycle; out_valid low in IDLE.
REQ-022 Latency: first byte valid the cycle after request handshake; minimum 7 cycles per value incl. 1 IDLE arbitration cycle.
REQ-023 req_data and req_valid changes during SEND SHALL NOT affect the bytes in flight.
REQ-024 out_ready held low SHALL stall indefinitely with no byte loss or duplication.

Reset
REQ-025 On rst_n low, SHALL asynchronously force: state IDLE, byte counter 0, value register 0, last_grant NUM_REQ-1 (requester 0 highest priority first).
REQ-026 During/after reset: out_valid=0, out_data=8'h00, busy=0, req_ready=0 while rst_n low.
REQ-027 Reset mid-SEND SHALL abandon the value; no remaining bytes emitted after release.

Structure
REQ-028 Package streamer_pkg SHALL hold state enum type, ASCII_ZERO=8'h30, ASCII_ONE=8'h31, BYTES_PER_VALUE=6.
REQ-029 SHALL instantiate existing bin_to_ascii_5 on the value register; byte select from its 40-bit output, top byte first.
REQ-030 Round-robin arbiter SHALL be inline logic; no further sub-modules.

Verification
REQ-031 Single: req_valid=4'b0001, req_data[4:0]=5'b10110, out_ready=1 -> req_ready=4'b0001 one cycle; bytes 31 30 31 31 30 20 on 6 consecutive cycles; busy falls after.
REQ-032 Fairness: all 4 valid continuously, out_ready=1 -> grant order 0,1,2,3,0; each grant separated by 7 cycles.
REQ-033 Backpressure: value 5'b00001, out_ready toggles 1,0,0,1... -> out_data holds during low; stream 30 30 30 30 31 20 exact, no duplicates.
REQ-034 Mid-stream reset: assert rst_n low after 2nd byte of 5'b11111 -> out_valid 0 immediately; after release, IDLE, next grant goes to requester 0.
REQ-035 Input change: req_data altered while SEND of 5'b01010 -> stream remains 30 31 30 31 30 20.
REQ-036 SEP_CHAR=8'h0A, NUM_REQ=2, requester 1 only, value 5'b00000 -> 30 30 30 30 30 0A; req_ready=2'b10.
